// File: rtl/best_1ofn_pipe_pkg.sv
// Shared sort definitions for the best-of-N pattern sorters.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: default pattern/key widths, sort-field slice positions, clog2.
package otmb_sort_pkg;

    // Pattern = 3 hit bits + 4 bend/ID bits, lsb = bend direction.
    localparam int MXPATB  = 7;
    // 1/2-strip key bits within one CFEB.
    localparam int MXKEYB  = 5;
    // Sort field is pat[sort_hi(w):SORT_LO]; the bend lsb never ranks.
    localparam int SORT_LO = 1;

    function automatic int sort_hi(input int patb);
        return patb - 1;
    endfunction

    // Ceiling log2, constant-evaluable for parameter derivation.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/best_1ofn_pipe_if.sv
// Candidate-set / best-result bundle between a producer and best_1ofn_pipe.
// Latency: n/a (wires only).
// Backpressure: none; a set is accepted every cycle valid_in is high.
// Ports: valid_in, cfeb_en, pat, key (to sorter); best_pat, best_key,
// valid_out (from sorter); second_pat/second_key when BEST_1OFN_SECOND_EN.
interface best_1ofn_pipe_if #(
    parameter int MXCFEB = 7,
    parameter int MXPATB = otmb_sort_pkg::MXPATB,
    parameter int MXKEYB = otmb_sort_pkg::MXKEYB
);
    import otmb_sort_pkg::*;

    localparam int MXKEYBX = clog2(MXCFEB) + MXKEYB;

    logic                      valid_in;
    logic [MXCFEB-1:0]         cfeb_en;
    logic [MXCFEB*MXPATB-1:0]  pat;
    logic [MXCFEB*MXKEYB-1:0]  key;
    logic [MXPATB-1:0]         best_pat;
    logic [MXKEYBX-1:0]        best_key;
    logic                      valid_out;

`ifdef BEST_1OFN_SECOND_EN
    logic [MXPATB-1:0]         second_pat;
    logic [MXKEYBX-1:0]        second_key;

    modport master (output valid_in, cfeb_en, pat, key,
                    input  best_pat, best_key, valid_out, second_pat, second_key);
    modport slave  (input  valid_in, cfeb_en, pat, key,
                    output best_pat, best_key, valid_out, second_pat, second_key);
`else
    modport master (output valid_in, cfeb_en, pat, key,
                    input  best_pat, best_key, valid_out);
    modport slave  (input  valid_in, cfeb_en, pat, key,
                    output best_pat, best_key, valid_out);
`endif

endinterface

// File: rtl/best_1ofn_pipe_node.sv
// One registered 2:1 node of the best-of-N tree (optional top-2 merge).
// Latency: 1 clock.
// Backpressure: none; data registers hold whenever i_vld is low.
// Ports: clock/reset; i_vld; lower-index side a, upper-index side b;
// o_vld/o_pat/o_key. Macro BEST_1OFN_SECOND_EN adds *_pat2/*_key2 lists.
module best_1of2_node #(
    parameter int PATB = otmb_sort_pkg::MXPATB,
    parameter int KEYB = otmb_sort_pkg::MXKEYB + 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_vld,
    input  logic [PATB-1:0] i_a_pat,
    input  logic [KEYB-1:0] i_a_key,
    input  logic [PATB-1:0] i_b_pat,
    input  logic [KEYB-1:0] i_b_key,
`ifdef BEST_1OFN_SECOND_EN
    input  logic [PATB-1:0] i_a_pat2,
    input  logic [KEYB-1:0] i_a_key2,
    input  logic [PATB-1:0] i_b_pat2,
    input  logic [KEYB-1:0] i_b_key2,
    output logic [PATB-1:0] o_pat2,
    output logic [KEYB-1:0] o_key2,
`endif
    output logic            o_vld,
    output logic [PATB-1:0] o_pat,
    output logic [KEYB-1:0] o_key
);
    import otmb_sort_pkg::*;

    localparam int SHI = sort_hi(PATB);

    logic            r_vld;
    logic [PATB-1:0] r_pat;
    logic [KEYB-1:0] r_key;
    logic            w_b_wins;

    // Upper side must be strictly greater, so equal sort values keep the
    // lower channel index.
    assign w_b_wins = i_b_pat[SHI:SORT_LO] > i_a_pat[SHI:SORT_LO];

`ifdef BEST_1OFN_SECOND_EN
    logic [PATB-1:0] r_pat2;
    logic [KEYB-1:0] r_key2;
    logic [PATB-1:0] w_s_pat;
    logic [KEYB-1:0] w_s_key;

    // Runner-up is the better of the losing first and the winning side's
    // second. Every a entry has a lower index than every b entry, so the
    // strict compare again sends ties to the lower index.
    always_comb begin
        w_s_pat = i_a_pat2;
        w_s_key = i_a_key2;
        if (w_b_wins) begin
            if (i_b_pat2[SHI:SORT_LO] > i_a_pat[SHI:SORT_LO]) begin
                w_s_pat = i_b_pat2;
                w_s_key = i_b_key2;
            end else begin
                w_s_pat = i_a_pat;
                w_s_key = i_a_key;
            end
        end else if (i_b_pat[SHI:SORT_LO] > i_a_pat2[SHI:SORT_LO]) begin
            w_s_pat = i_b_pat;
            w_s_key = i_b_key;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pat2 <= '0;
            r_key2 <= '0;
        end else if (i_vld) begin
            r_pat2 <= w_s_pat;
            r_key2 <= w_s_key;
        end
    end

    assign o_pat2 = r_pat2;
    assign o_key2 = r_key2;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= 1'b0;
            r_pat <= '0;
            r_key <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_pat <= w_b_wins ? i_b_pat : i_a_pat;
                r_key <= w_b_wins ? i_b_key : i_a_key;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_pat = r_pat;
    assign o_key = r_key;

endmodule

// File: rtl/best_1ofn_pipe.sv
// Pipelined best-of-N CFEB pattern sorter: binary tree of registered nodes.
// Latency: clog2(MXCFEB) clocks from valid_in to valid_out.
// Backpressure: none; accepts one candidate set per clock, never stalls.
// Ports: clock, reset (sync, active-high); bus (best_1ofn_pipe_if.slave).
// Macro BEST_1OFN_SECOND_EN adds the runner-up outputs second_pat/second_key.
module best_1ofn_pipe #(
    parameter int MXCFEB = 7,
    parameter int MXPATB = otmb_sort_pkg::MXPATB,
    parameter int MXKEYB = otmb_sort_pkg::MXKEYB
) (
    input  logic            clock,
    input  logic            reset,
    best_1ofn_pipe_if.slave bus
);
    import otmb_sort_pkg::*;

    localparam int MXCFEBB = clog2(MXCFEB);
    localparam int MXKEYBX = MXCFEBB + MXKEYB;
    localparam int NLEAF   = 1 << MXCFEBB;

    // Heap-ordered tree: node n has children 2n (lower index) and 2n+1;
    // leaves sit at NLEAF+channel, the root at 1.
    logic [MXPATB-1:0]  w_pat [1:2*NLEAF-1];
    logic [MXKEYBX-1:0] w_key [1:2*NLEAF-1];
    logic               w_vld [1:NLEAF-1];
`ifdef BEST_1OFN_SECOND_EN
    logic [MXPATB-1:0]  w_pat2 [1:2*NLEAF-1];
    logic [MXKEYBX-1:0] w_key2 [1:2*NLEAF-1];
`endif

    genvar g;
    for (g = 0; g < NLEAF; g++) begin : g_leaf
        if (g < MXCFEB) begin : g_real
            // Masked channels keep their index so an all-masked set still
            // reports channel 0; the index is attached here once only.
            assign w_pat[NLEAF+g] = bus.cfeb_en[g] ? bus.pat[g*MXPATB +: MXPATB] : '0;
            assign w_key[NLEAF+g] = {MXCFEBB'(g),
                                     bus.cfeb_en[g] ? bus.key[g*MXKEYB +: MXKEYB] : MXKEYB'(0)};
        end else begin : g_pad
            assign w_pat[NLEAF+g] = '0;
            assign w_key[NLEAF+g] = '0;
        end
`ifdef BEST_1OFN_SECOND_EN
        assign w_pat2[NLEAF+g] = '0;
        assign w_key2[NLEAF+g] = '0;
`endif
    end

    for (g = 1; g < NLEAF; g++) begin : g_node
        logic w_in_vld;
        if (g >= NLEAF / 2) begin : g_bottom
            assign w_in_vld = bus.valid_in;
        end else begin : g_inner
            // Both children always carry the same valid; using both keeps
            // every rank's valid consumed.
            assign w_in_vld = w_vld[2*g] & w_vld[2*g+1];
        end

        best_1of2_node #(
            .PATB (MXPATB),
            .KEYB (MXKEYBX)
        ) u_node (
            .clock    (clock),
            .reset    (reset),
            .i_vld    (w_in_vld),
            .i_a_pat  (w_pat[2*g]),
            .i_a_key  (w_key[2*g]),
            .i_b_pat  (w_pat[2*g+1]),
            .i_b_key  (w_key[2*g+1]),
`ifdef BEST_1OFN_SECOND_EN
            .i_a_pat2 (w_pat2[2*g]),
            .i_a_key2 (w_key2[2*g]),
            .i_b_pat2 (w_pat2[2*g+1]),
            .i_b_key2 (w_key2[2*g+1]),
            .o_pat2   (w_pat2[g]),
            .o_key2   (w_key2[g]),
`endif
            .o_vld    (w_vld[g]),
            .o_pat    (w_pat[g]),
            .o_key    (w_key[g])
        );
    end

    assign bus.valid_out = w_vld[1];
    assign bus.best_pat  = w_pat[1];
    assign bus.best_key  = w_key[1];
`ifdef BEST_1OFN_SECOND_EN
    assign bus.second_pat = w_pat2[1];
    assign bus.second_key = w_key2[1];
`endif

endmodule

// File: tb/tb_best_1ofn_pipe.sv
// Self-checking bench for best_1ofn_pipe (MXCFEB=7): directed + random sets
// compared slot-by-slot against a linear-scan reference model.
module tb_best_1ofn_pipe;
    localparam int NCH   = 7;
    localparam int PB    = 7;
    localparam int KB    = 5;
    localparam int KX    = 8;
    localparam int LAT   = 3;
    localparam int NSLOT = 1024;

    logic clock = 1'b0;
    logic reset;

    best_1ofn_pipe_if #(.MXCFEB(NCH), .MXPATB(PB), .MXKEYB(KB)) bus ();

    best_1ofn_pipe #(.MXCFEB(NCH), .MXPATB(PB), .MXKEYB(KB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int slot  = 0;
    int sec_slot = -1;
    logic [KX-1:0] sec_key;

    bit            exp_vld [NSLOT];
    logic [PB-1:0] exp_pat [NSLOT];
    logic [KX-1:0] exp_key [NSLOT];
    logic [PB-1:0] last_pat;
    logic [KX-1:0] last_key;

    logic [NCH-1:0]    en;
    logic [NCH*PB-1:0] p;
    logic [NCH*KB-1:0] k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s slot=%0d got=%0h expected=%0h", tag, slot, got, exp);
        end
    endtask

    // Reference: scan channels in order, keep the first strictly larger
    // pat/2; masked channels contribute pat=0, key=0.
    function automatic void ref_best(input logic [NCH-1:0] e, input logic [NCH*PB-1:0] pv,
                                     input logic [NCH*KB-1:0] kv,
                                     output logic [PB-1:0] bp, output logic [KX-1:0] bk);
        int best_sv;
        int pi;
        int ki;
        best_sv = -1;
        bp = '0;
        bk = '0;
        for (int i = 0; i < NCH; i++) begin
            pi = e[i] ? int'(pv[i*PB +: PB]) : 0;
            ki = e[i] ? int'(kv[i*KB +: KB]) : 0;
            if (pi / 2 > best_sv) begin
                best_sv = pi / 2;
                bp = PB'(pi);
                bk = KX'(i * (1 << KB) + ki);
            end
        end
    endfunction

    task automatic drive(input bit v, input logic [NCH-1:0] e, input logic [NCH*PB-1:0] pv,
                         input logic [NCH*KB-1:0] kv, input bit r);
        logic [PB-1:0] bp;
        logic [KX-1:0] bk;
        bus.valid_in = v;
        bus.cfeb_en  = e;
        bus.pat      = pv;
        bus.key      = kv;
        reset        = r;
        if (r) begin
            for (int d = 1; d <= LAT; d++) exp_vld[slot+d] = 1'b0;
        end else if (v) begin
            ref_best(e, pv, kv, bp, bk);
            exp_vld[slot+LAT] = 1'b1;
            exp_pat[slot+LAT] = bp;
            exp_key[slot+LAT] = bk;
        end
    endtask

    task automatic tick();
        bit rst_seen;
        rst_seen = reset;
        @(posedge clock);
        #1;
        slot++;
        if (rst_seen) begin
            last_pat = '0;
            last_key = '0;
        end
        if (exp_vld[slot]) begin
            check("valid_out", 32'(bus.valid_out), 32'd1);
            check("best_pat", 32'(bus.best_pat), 32'(exp_pat[slot]));
            check("best_key", 32'(bus.best_key), 32'(exp_key[slot]));
            last_pat = exp_pat[slot];
            last_key = exp_key[slot];
        end else begin
            check("idle_valid", 32'(bus.valid_out), 32'd0);
            check("hold_pat", 32'(bus.best_pat), 32'(last_pat));
            check("hold_key", 32'(bus.best_key), 32'(last_key));
        end
`ifdef BEST_1OFN_SECOND_EN
        if (slot == sec_slot) begin
            check("second_pat", 32'(bus.second_pat), 32'h61);
            check("second_key", 32'(bus.second_key), 32'(sec_key));
        end
`endif
    endtask

    task automatic cyc(input bit v, input logic [NCH-1:0] e, input logic [NCH*PB-1:0] pv,
                       input logic [NCH*KB-1:0] kv, input bit r);
        drive(v, e, pv, kv, r);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic fill(input logic [PB-1:0] base);
        for (int i = 0; i < NCH; i++) begin
            p[i*PB +: PB] = base;
            k[i*KB +: KB] = KB'($urandom);
        end
    endtask

    initial begin
        last_pat = '0;
        last_key = '0;
        for (int i = 0; i < NSLOT; i++) exp_vld[i] = 1'b0;

        // Reset with valid_in high: must be ignored, outputs all zero.
        fill(7'h33);
        cyc(1'b1, '1, p, k, 1'b1);
        cyc(1'b1, '1, p, k, 1'b1);
        idle(4);

        // Single clear winner on channel 3, key 17 -> best_key 8'h71.
        fill(7'h20);
        p[3*PB +: PB] = 7'h50;
        k[3*KB +: KB] = 5'd17;
        cyc(1'b1, 7'h7f, p, k, 1'b0);
        idle(4);

        // Exact tie between channels 2 and 5: lower index wins.
        fill(7'h10);
        p[2*PB +: PB] = 7'h61;
        p[5*PB +: PB] = 7'h61;
        sec_slot = slot + LAT;
        sec_key  = KX'(5 * 32 + int'(k[5*KB +: KB]));
        cyc(1'b1, 7'h7f, p, k, 1'b0);
        idle(4);

        // Equal sort value, differing lsb: channel 1 (7'h41) beats 4 (7'h40).
        fill(7'h10);
        p[1*PB +: PB] = 7'h41;
        p[4*PB +: PB] = 7'h40;
        cyc(1'b1, 7'h7f, p, k, 1'b0);
        idle(4);

        // Channel 3 masked although highest: channel 6 wins.
        fill(7'h10);
        p[3*PB +: PB] = 7'h7e;
        p[6*PB +: PB] = 7'h60;
        cyc(1'b1, 7'b1110111, p, k, 1'b0);
        // Everything masked: channel 0, zeros, still valid.
        cyc(1'b1, 7'b0000000, p, k, 1'b0);
        idle(4);

        // Seven back-to-back sets, maximum rotating across channels 0..6.
        for (int n = 0; n < NCH; n++) begin
            fill(7'h10);
            p[n*PB +: PB] = 7'h70;
            cyc(1'b1, 7'h7f, p, k, 1'b0);
        end
        idle(4);

        // Reset for one clock with two sets in flight; nothing may emerge.
        fill(7'h22);
        p[4*PB +: PB] = 7'h66;
        cyc(1'b1, 7'h7f, p, k, 1'b0);
        cyc(1'b1, 7'h7f, p, k, 1'b0);
        cyc(1'b0, 7'h7f, p, k, 1'b1);
        idle(5);
        fill(7'h12);
        p[5*PB +: PB] = 7'h3c;
        cyc(1'b1, 7'h7f, p, k, 1'b0);
        idle(4);

        // Random sets with frequent sort-value ties and occasional resets.
        for (int it = 0; it < 300; it++) begin
            bit v;
            bit r;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 49) == 0);
            en = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '1;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 4) == 0)
                    p[i*PB +: PB] = PB'($urandom);
                else
                    p[i*PB +: PB] = PB'(($urandom_range(0, 3) << 4) | $urandom_range(0, 1));
                k[i*KB +: KB] = KB'($urandom);
            end
            cyc(v, en, p, k, r);
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
